// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 4:1 lane serializer.
package mux_pkg;
  localparam int LANES = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_e;
endpackage

// File: rtl/mux41_shadow_reg.sv
// Four-lane capture register (data + valid) with an indexed read port.
module mux41_shadow_reg
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [LANES-1:0]                 valid_i,
  input  logic [IDX_W-1:0]                 rd_idx_i,
  output logic [DATA_WIDTH-1:0]            rd_data_o,
  output logic                             rd_valid_o
);

  logic [LANES-1:0][DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0]                 valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (en_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/mux_4to1_serializer.sv
// Serializes one 4-lane word onto a byte stream, lane 0 first, one slot per clk.
// States: IDLE | waiting for a word, outputs held at 0
//         SER  | emitting shadow lane idx each cycle
module mux_4to1_serializer
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  valid_in0,
  input  logic                  valid_in1,
  input  logic                  valid_in2,
  input  logic                  valid_in3,
  input  logic                  load,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sof_out
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    valid_out_q, valid_out_d;
  logic                    sof_out_q, sof_out_d;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  // Ready at idx==3 lets a new word land on the same edge as the old lane 3.
  assign ready  = reset && ((state_q == IDLE) || (idx_q == LAST_IDX));
  assign accept = load && ready;

  mux41_shadow_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .en_i      (accept),
    .data_i    ({data_in3, data_in2, data_in1, data_in0}),
    .valid_i   ({valid_in3, valid_in2, valid_in1, valid_in0}),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_out_d  = '0;
    valid_out_d = 1'b0;
    sof_out_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SER;
          idx_d   = '0;
        end
      end
      SER: begin
        data_out_d  = rd_data;
        valid_out_d = rd_valid;
        sof_out_d   = (idx_q == '0);
        idx_d       = idx_q + 1'b1;
        if ((idx_q == LAST_IDX) && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;

endmodule

// File: tb/tb_mux_4to1_serializer.sv
// Scoreboard bench for mux_4to1_serializer: table of single words plus hand sequences.
module tb_mux_4to1_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       valid_in0, valid_in1, valid_in2, valid_in3;
  logic       load;
  logic       ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sof_out;

  always #5 clk = ~clk;

  mux_4to1_serializer #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .valid_in0(valid_in0),
    .valid_in1(valid_in1),
    .valid_in2(valid_in2),
    .valid_in3(valid_in3),
    .load     (load),
    .ready    (ready),
    .data_out (data_out),
    .valid_out(valid_out),
    .sof_out  (sof_out)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       s;
  } slot_t;

  typedef struct {
    logic [7:0] d[4];
    logic [3:0] v;
    logic [7:0] exp_d[4];
    logic [3:0] exp_v;
  } vec_t;

  slot_t      sb_q[$];
  vec_t       tbl[3];
  logic [7:0] exp_d[4];
  logic [3:0] exp_v;
  int         n_pass = 0;
  int         n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  task automatic set_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [3:0] v);
    data_in0 = a; data_in1 = b; data_in2 = c; data_in3 = d;
    valid_in0 = v[0]; valid_in1 = v[1]; valid_in2 = v[2]; valid_in3 = v[3];
    exp_d[0] = a; exp_d[1] = b; exp_d[2] = c; exp_d[3] = d;
    exp_v = v;
  endtask

  // One clock: check ready before the edge, then the output slot after it.
  task automatic cycle();
    logic  er, acc;
    slot_t e, p;
    #2;
    er  = reset && (sb_q.size() <= 1);
    check("ready", 32'(ready), 32'(er));
    acc = load && er;
    @(posedge clk);
    #1;
    if (!reset) begin
      sb_q.delete();
      e = '0;
    end else begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          p.d = exp_d[k];
          p.v = exp_v[k];
          p.s = (k == 0);
          sb_q.push_back(p);
        end
      end
    end
    check("slot{data,valid,sof}", 32'({data_out, valid_out, sof_out}), 32'(e));
  endtask

  initial begin
    tbl[0].d = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].v = 4'b1111;
    tbl[0].exp_d = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].exp_v = 4'b1111;
    tbl[1].d = '{8'h5A, 8'h5B, 8'h5C, 8'h5D}; tbl[1].v = 4'b0101;
    tbl[1].exp_d = '{8'h5A, 8'h5B, 8'h5C, 8'h5D}; tbl[1].exp_v = 4'b0101;
    tbl[2].d = '{8'h00, 8'hFF, 8'h81, 8'h7E}; tbl[2].v = 4'b1000;
    tbl[2].exp_d = '{8'h00, 8'hFF, 8'h81, 8'h7E}; tbl[2].exp_v = 4'b1000;

    reset = 1'b0;
    load  = 1'b0;
    set_word(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    repeat (2) cycle();
    reset = 1'b1;
    cycle();

    for (int i = 0; i < 3; i++) begin
      data_in0 = tbl[i].d[0]; data_in1 = tbl[i].d[1];
      data_in2 = tbl[i].d[2]; data_in3 = tbl[i].d[3];
      valid_in0 = tbl[i].v[0]; valid_in1 = tbl[i].v[1];
      valid_in2 = tbl[i].v[2]; valid_in3 = tbl[i].v[3];
      for (int k = 0; k < 4; k++) exp_d[k] = tbl[i].exp_d[k];
      exp_v = tbl[i].exp_v;
      load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (5) cycle();
    end

    // Back-to-back words with load held high: B lands on A's lane-3 edge.
    set_word(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111);
    load = 1'b1;
    cycle();
    set_word(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1111);
    repeat (4) cycle();
    load = 1'b0;
    repeat (5) cycle();

    // Lane inputs changing after acceptance must not reach the output.
    set_word(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
    load = 1'b1;
    cycle();
    load = 1'b0;
    data_in0 = 8'hFF; data_in1 = 8'hFF; data_in2 = 8'hFF; data_in3 = 8'hFF;
    valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
    repeat (5) cycle();

    // Reset after lane 1 is out abandons the word.
    set_word(8'h61, 8'h62, 8'h63, 8'h64, 4'b1111);
    load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    set_word(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b1111);
    load = 1'b1;
    cycle();
    load = 1'b0;
    repeat (5) cycle();

    // load held across reset and afterwards: accepted at IDLE, then every 4 clk.
    reset = 1'b0;
    set_word(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'b0110);
    load = 1'b1;
    repeat (2) cycle();
    reset = 1'b1;
    repeat (12) cycle();
    load = 1'b0;
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
